// File: rtl/mips_pkg.sv
// Shared MIPS decode constants and the multiply/divide sequencer state encoding.
`default_nettype none
package mips_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] F_MULT   = 6'b011000;
  localparam logic [5:0] F_MULTU  = 6'b011001;
  localparam logic [5:0] F_DIV    = 6'b011010;
  localparam logic [5:0] F_DIVU   = 6'b011011;
  localparam logic [5:0] F_MFHI   = 6'b010000;
  localparam logic [5:0] F_MTHI   = 6'b010001;
  localparam logic [5:0] F_MFLO   = 6'b010010;
  localparam logic [5:0] F_MTLO   = 6'b010011;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    WB   = 2'b10
  } md_state_t;
endpackage
`default_nettype wire

// File: rtl/md_decode.sv
// Combinational classifier for mult/div and HI/LO-access instructions in ID.
`default_nettype none
module md_decode
  import mips_pkg::*;
(
  input  logic       id_valid,
  input  logic [5:0] id_op,
  input  logic [5:0] id_func,
  output logic       md_op,
  output logic       hilo_op,
  output logic       is_div,
  output logic       is_signed
);
  logic rtype;
  assign rtype = id_valid && (id_op == OP_RTYPE);

  always_comb begin
    md_op     = 1'b0;
    hilo_op   = 1'b0;
    is_div    = 1'b0;
    is_signed = 1'b0;
    if (rtype) begin
      case (id_func)
        F_MULT:  begin md_op = 1'b1; is_signed = 1'b1; end
        F_MULTU: begin md_op = 1'b1; end
        F_DIV:   begin md_op = 1'b1; is_div = 1'b1; is_signed = 1'b1; end
        F_DIVU:  begin md_op = 1'b1; is_div = 1'b1; end
        F_MFHI, F_MTHI, F_MFLO, F_MTLO: hilo_op = 1'b1;
        default: ;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: rtl/muldiv_issue_ctrl.sv
// Issues mult/div into the iterative unit, times its latency, strobes HI/LO
// and merges load-use and mult/div stalls into the pipeline freeze controls.
`default_nettype none
module muldiv_issue_ctrl
  import mips_pkg::*;
#(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       id_valid,
  input  logic [5:0] id_op,
  input  logic [5:0] id_func,
  input  logic       load_stall,
  output logic       md_start,
  output logic       md_is_div,
  output logic       md_signed,
  output logic       hilo_we,
  output logic       md_busy,
  output logic       stall,
  output logic       pc_we,
  output logic       ifid_we,
  output logic       idex_bubble
);
  localparam logic [5:0] MUL_LOAD = 6'(MUL_CYCLES - 2);
  localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 2);

  md_state_t  state, state_nx;
  logic [5:0] cnt, cnt_nx;
  logic       op_div, op_div_nx, op_signed, op_signed_nx;
  logic       dec_md, dec_hilo, dec_div, dec_signed;
  logic       busy_raw, md_stall, issue;

  md_decode u_decode (
    .id_valid  (id_valid),
    .id_op     (id_op),
    .id_func   (id_func),
    .md_op     (dec_md),
    .hilo_op   (dec_hilo),
    .is_div    (dec_div),
    .is_signed (dec_signed)
  );

  // Outputs are gated by rst_n so the reset cycle itself is quiet.
  assign busy_raw = (state != IDLE);
  assign md_stall = rst_n && busy_raw && (dec_md || dec_hilo);
  assign issue    = rst_n && (state == IDLE) && dec_md && !load_stall;

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    op_div_nx    = op_div;
    op_signed_nx = op_signed;
    case (state)
      IDLE: if (issue) begin
        state_nx     = RUN;
        cnt_nx       = dec_div ? DIV_LOAD : MUL_LOAD;
        op_div_nx    = dec_div;
        op_signed_nx = dec_signed;
      end
      RUN: if (cnt == 6'd0) state_nx = WB;
           else cnt_nx = cnt - 6'd1;
      WB:      state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 6'd0;
      op_div    <= 1'b0;
      op_signed <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      op_div    <= op_div_nx;
      op_signed <= op_signed_nx;
    end
  end

  // Outside the issue cycle the kind outputs report the in-flight op.
  assign md_start    = issue;
  assign md_is_div   = issue ? dec_div    : (rst_n && busy_raw && op_div);
  assign md_signed   = issue ? dec_signed : (rst_n && busy_raw && op_signed);
  assign hilo_we     = rst_n && (state == WB);
  assign md_busy     = rst_n && busy_raw;
  assign stall       = rst_n && (load_stall || md_stall);
  assign pc_we       = !stall;
  assign ifid_we     = !stall;
  assign idex_bubble = stall;
endmodule
`default_nettype wire

// File: tb/tb_muldiv_issue_ctrl.sv
// Self-checking bench: two instances (default latencies and short latencies) against a countdown model.
`default_nettype none
module tb_muldiv_issue_ctrl;
  localparam logic [5:0] RT = 6'b000000, ADDI = 6'b001000;
  localparam logic [5:0] MULT = 6'b011000, MULTU = 6'b011001, DIV = 6'b011010, DIVU = 6'b011011;
  localparam logic [5:0] MFHI = 6'b010000, MTHI = 6'b010001, MFLO = 6'b010010, MTLO = 6'b010011;
  localparam logic [5:0] ADD = 6'b100000, SUB = 6'b100010;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, id_valid, load_stall;
  logic [5:0] id_op, id_func;
  logic a_start, a_div, a_sgn, a_hwe, a_busy, a_stall, a_pc, a_ifid, a_bub;
  logic b_start, b_div, b_sgn, b_hwe, b_busy, b_stall, b_pc, b_ifid, b_bub;

  muldiv_issue_ctrl #(.MUL_CYCLES(4), .DIV_CYCLES(32)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_op(id_op), .id_func(id_func),
    .load_stall(load_stall), .md_start(a_start), .md_is_div(a_div), .md_signed(a_sgn),
    .hilo_we(a_hwe), .md_busy(a_busy), .stall(a_stall), .pc_we(a_pc), .ifid_we(a_ifid),
    .idex_bubble(a_bub));

  muldiv_issue_ctrl #(.MUL_CYCLES(3), .DIV_CYCLES(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_op(id_op), .id_func(id_func),
    .load_stall(load_stall), .md_start(b_start), .md_is_div(b_div), .md_signed(b_sgn),
    .hilo_we(b_hwe), .md_busy(b_busy), .stall(b_stall), .pc_we(b_pc), .ifid_we(b_ifid),
    .idex_bubble(b_bub));

  int errors = 0;
  int checks = 0;
  int rem[2] = '{0, 0};            // cycles until the unit is free again
  int mul_n[2] = '{4, 3};
  int div_n[2] = '{32, 2};
  string nm[9] = '{"md_start", "md_is_div", "md_signed", "hilo_we", "md_busy",
                   "stall", "pc_we", "ifid_we", "idex_bubble"};

  typedef struct {
    logic       r;
    logic       v;
    logic [5:0] op;
    logic [5:0] fn;
    logic       ld;
  } vec_t;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: drive, sample mid-cycle, compare both DUTs to the model, advance model.
  task automatic step(input logic r, input logic v, input logic [5:0] op,
                      input logic [5:0] fn, input logic ld);
    logic [8:0] act, exp;
    bit rt, md, hl, busy, iss, mds, st, dv, sg;
    @(negedge clk);
    rst_n = r; id_valid = v; id_op = op; id_func = fn; load_stall = ld;
    #1;
    rt = v && (op == RT);
    md = rt && (fn == MULT || fn == MULTU || fn == DIV || fn == DIVU);
    hl = rt && (fn == MFHI || fn == MTHI || fn == MFLO || fn == MTLO);
    dv = (fn == DIV || fn == DIVU);
    sg = (fn == MULT || fn == DIV);
    for (int k = 0; k < 2; k++) begin
      busy = rem[k] > 0;
      mds  = r && busy && (md || hl);
      iss  = r && !busy && md && !ld;
      st   = r && (ld || mds);
      exp  = {iss, iss && dv, iss && sg, r && rem[k] == 1, r && busy, st, !st, !st, st};
      act  = (k == 0) ? {a_start, a_div, a_sgn, a_hwe, a_busy, a_stall, a_pc, a_ifid, a_bub}
                      : {b_start, b_div, b_sgn, b_hwe, b_busy, b_stall, b_pc, b_ifid, b_bub};
      for (int i = 0; i < 9; i++) begin
        // kind outputs are only defined at issue and in reset
        if ((i == 1 || i == 2) && !iss && r) continue;
        chk($sformatf("dut%0d %s", k, nm[i]), act[8-i], exp[8-i]);
      end
      if (!r) rem[k] = 0;
      else if (iss) rem[k] = dv ? div_n[k] : mul_n[k];
      else if (rem[k] > 0) rem[k]--;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, RT, ADD, 0);
  endtask

  vec_t tbl[$];
  logic [5:0] fpool[11] = '{MULT, MULTU, DIV, DIVU, MFHI, MTHI, MFLO, MTLO, ADD, SUB, ADD};

  initial begin
    rst_n = 0; id_valid = 0; id_op = RT; id_func = ADD; load_stall = 0;

    // Reset held with MULT in ID, then release
    step(0, 1, RT, MULT, 0);
    step(0, 1, RT, MULT, 0);
    chk("rst md_start", a_start, 1'b0);
    chk("rst pc_we", a_pc, 1'b1);
    chk("rst md_busy", a_busy, 1'b0);
    step(1, 1, RT, MULT, 0);
    chk("rel md_start", a_start, 1'b1);
    chk("rel md_is_div", a_div, 1'b0);
    chk("rel md_signed", a_sgn, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, RT, ADD, 0);
      chk("add no stall", a_stall, 1'b0);
    end
    step(1, 1, RT, MFLO, 0);
    chk("wb hilo_we", a_hwe, 1'b1);
    chk("wb mflo stall", a_stall, 1'b1);
    chk("wb mflo bubble", a_bub, 1'b1);
    chk("wb mflo pc_we", a_pc, 1'b0);
    step(1, 1, RT, MFLO, 0);
    chk("mflo released", a_stall, 1'b0);

    // MULTU, then hilo_we exactly four cycles later
    step(1, 1, RT, MULTU, 0);
    chk("multu signed", a_sgn, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      step(1, 1, RT, ADD, 0);
      chk($sformatf("multu hilo_we T+%0d", i), a_hwe, i == 4);
    end

    // DIV then DIVU held for the whole latency
    step(1, 1, RT, DIV, 0);
    chk("div is_div", a_div, 1'b1);
    for (int i = 1; i <= 32; i++) begin
      step(1, 1, RT, DIVU, 0);
      chk("divu held", a_stall, 1'b1);
    end
    step(1, 1, RT, DIVU, 0);
    chk("divu issue", a_start, 1'b1);
    chk("divu signed", a_sgn, 1'b0);
    idle(32);

    // load_stall blocks issue for one cycle
    step(1, 1, RT, MULT, 1);
    chk("ld md_start", a_start, 1'b0);
    chk("ld stall", a_stall, 1'b1);
    step(1, 1, RT, MULT, 0);
    chk("ld retry start", a_start, 1'b1);
    chk("ld retry stall", a_stall, 1'b0);
    idle(4);

    // Reset mid-divide drops the result
    step(1, 1, RT, DIV, 0);
    idle(9);
    step(0, 0, RT, ADD, 0);
    step(1, 0, RT, ADD, 0);
    chk("mid rst busy", a_busy, 1'b0);
    for (int i = 12; i <= 40; i++) begin
      step(1, 0, RT, ADD, 0);
      chk("mid rst hilo_we", a_hwe, 1'b0);
    end

    // Short divide on the second instance, back-to-back
    step(1, 1, RT, DIV, 0);
    chk("short div start", b_start, 1'b1);
    step(1, 1, RT, DIV, 0);
    chk("short div stall", b_stall, 1'b1);
    step(1, 1, RT, DIV, 0);
    chk("short div hilo_we", b_hwe, 1'b1);
    step(1, 1, RT, DIV, 0);
    chk("short div reissue", b_start, 1'b1);
    step(0, 0, RT, ADD, 0);

    // Table of mixed vectors, all checked by the model
    tbl.push_back('{1, 1, RT, MTHI, 0});
    tbl.push_back('{1, 1, ADDI, MULT, 0});
    tbl.push_back('{1, 0, RT, MULT, 0});
    tbl.push_back('{1, 1, RT, MULTU, 0});
    tbl.push_back('{1, 1, RT, MTLO, 0});
    tbl.push_back('{1, 1, RT, SUB, 1});
    tbl.push_back('{1, 1, RT, MFHI, 1});
    tbl.push_back('{1, 1, RT, ADD, 0});
    tbl.push_back('{1, 1, RT, DIVU, 0});
    tbl.push_back('{1, 1, RT, MFHI, 0});
    tbl.push_back('{0, 1, RT, DIV, 1});
    tbl.push_back('{1, 1, RT, DIV, 1});
    foreach (tbl[i]) step(tbl[i].r, tbl[i].v, tbl[i].op, tbl[i].fn, tbl[i].ld);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 63) != 0, $urandom_range(0, 7) != 0,
           ($urandom_range(0, 9) == 0) ? ADDI : RT,
           fpool[$urandom_range(0, 10)], $urandom_range(0, 3) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/muldiv_issue_ctrl.md
# muldiv_issue_ctrl

Sequencer for the shared iterative multiply/divide unit and the HI/LO register pair in the 5-stage MIPS pipeline. It sits beside the ID-stage load-use hazard logic. It issues MULT/MULTU/DIV/DIVU into the unit and counts the operation's latency. It raises the HI/LO write strobe and merges the load-use stall with its own structural/RAW stall into the pipeline-wide freeze controls. Independent instructions keep flowing while the unit is busy; only HI/LO-touching instructions are held in ID.

## Interface
- MUL_CYCLES, default 4: total latency of a multiply, issue to HI/LO write; legal range 2..63.
- DIV_CYCLES, default 32: total latency of a divide, issue to HI/LO write; legal range 2..63.
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- id_valid  in  1  ID holds a real instruction (0 = bubble).
- id_op  in  6  ID instruction opcode field.
- id_func  in  6  ID instruction function field.
- load_stall  in  1  load-use stall request from the ID hazard logic.
- md_start  out  1  one-cycle issue pulse; the datapath latches rs/rt operands on this edge.
- md_is_div  out  1  valid with md_start: 1 = divide, 0 = multiply.
- md_signed  out  1  valid with md_start: 1 = MULT/DIV, 0 = MULTU/DIVU.
- hilo_we  out  1  one-cycle HI/LO write strobe for the unit's result.
- md_busy  out  1  state is not IDLE.
- stall  out  1  combined stall, equal to load_stall OR md_stall.
- pc_we  out  1  PC write enable, equal to NOT stall.
- ifid_we  out  1  IF/ID register write enable, equal to NOT stall.
- idex_bubble  out  1  insert a NOP into ID/EX this cycle, equal to stall.

## Operation
- Decode applies only when id_valid=1 and id_op=000000.
- md_op is true for func 011000 (MULT), 011001 (MULTU), 011010 (DIV) and 011011 (DIVU).
- hilo_op is true for func 010000 (MFHI), 010001 (MTHI), 010010 (MFLO) and 010011 (MTLO).
- md_stall is true when the state is not IDLE and (md_op OR hilo_op).
- issue is true when the state is IDLE, md_op is true and load_stall=0. md_start equals issue.
- FSM states:
  - IDLE: on issue, go to RUN and load cnt = (is_div ? DIV_CYCLES : MUL_CYCLES) − 2.
  - RUN: if cnt==0, go to WB; otherwise decrement cnt.
  - WB: assert hilo_we, go to IDLE.
- The op kind is latched at issue and held until WB.
- cnt width is 6 bits unsigned. It never wraps, because RUN exits at 0.
- A divide by zero is not special-cased: it takes the full latency and hilo_we still fires. The datapath defines the result.
- Issue and stall are exclusive by construction: issue requires IDLE, and md_stall requires not IDLE.
- load_stall=1 with md_op in IDLE gives no issue. The instruction retries next cycle with no state change.
- WB counts as busy. An mfhi/mflo in ID during WB stalls one more cycle and reads the new HI/LO in IDLE.
- Non-HI/LO instructions in ID during RUN/WB do not stall.
- rst_n=0 at any cycle, including mid-RUN: next state IDLE, cnt=0, and the in-flight result is dropped. No hilo_we is asserted in the reset cycle or after it.

## Timing
- Reset values: state IDLE and cnt 0. Every output is 0 except pc_we=1 and ifid_we=1; stall, idex_bubble and md_busy are 0.
- All outputs are combinational from registered state plus current inputs. The only registered elements are state, cnt and op kind.
- For an issue in cycle T:
  - md_busy=1 in cycles T+1 .. T+N, where N is MUL_CYCLES or DIV_CYCLES.
  - hilo_we=1 in cycle T+N only.
  - The earliest next issue is cycle T+N+1.
- MUL_CYCLES=4: RUN lasts cycles T+1..T+3 and WB is cycle T+4.
- Stall semantics: while stall=1, PC and IF/ID hold and ID/EX receives a bubble. load_stall alone reproduces the existing one-cycle load-use behaviour.

## Structure
- Shared package mips_pkg holds:
  - opcode/func localparams: OP_RTYPE, F_MULT, F_MULTU, F_DIV, F_DIVU, F_MFHI, F_MTHI, F_MFLO, F_MTLO;
  - the state encoding, md_state_t: IDLE=2'b00, RUN=2'b01, WB=2'b10.
- One sub-module, md_decode, is combinational. It maps id_valid, id_op and id_func to md_op, hilo_op, is_div and is_signed, and is reused by the datapath's HI/LO mux.
- The FSM and counter live in muldiv_issue_ctrl.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with MULT in ID -> md_start=0, pc_we=1, all other outputs 0. After release with MULT in ID: md_start=1, md_is_div=0, md_signed=1.
- MULTU issued at T, then ADD, ADD, ADD, MFLO -> stall=0 on the ADDs. hilo_we=1 exactly at T+4. MFLO in ID at T+4 gives stall=1, idex_bubble=1, pc_we=0; released at T+5.
- DIV issued at T, DIVU in ID at T+1 -> stall=1 for cycles T+1..T+32. DIVU md_start=1 at T+33 with md_signed=0.
- load_stall=1 with MULT in ID in IDLE -> md_start=0, stall=1. Next cycle load_stall=0 -> md_start=1, stall=0.
- DIV issued at T, rst_n=0 at T+10 -> state IDLE at T+11. hilo_we stays 0 through T+40.
- DIV_CYCLES=2: DIV at T -> one RUN cycle, hilo_we at T+2. Back-to-back DIV in ID at T+1 issues at T+3.
